// File: rtl/ysyx_23060208_mem_arbiter.sv
// Round-robin arbiter sharing one memory port between IFU and LSU, with a
// single outstanding transaction and a response timeout.
module ysyx_23060208_mem_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    ifu_req_valid,
    output logic                    ifu_req_ready,
    input  logic [DATA_WIDTH-1:0]   ifu_addr,
    output logic                    ifu_resp_valid,
    output logic [DATA_WIDTH-1:0]   ifu_resp_data,
    output logic                    ifu_resp_err,

    input  logic                    lsu_req_valid,
    output logic                    lsu_req_ready,
    input  logic [DATA_WIDTH-1:0]   lsu_addr,
    input  logic                    lsu_wen,
    input  logic [DATA_WIDTH-1:0]   lsu_wdata,
    input  logic [DATA_WIDTH/8-1:0] lsu_wmask,
    output logic                    lsu_resp_valid,
    output logic [DATA_WIDTH-1:0]   lsu_resp_data,
    output logic                    lsu_resp_err,

    output logic                    mem_req_valid,
    input  logic                    mem_req_ready,
    output logic [DATA_WIDTH-1:0]   mem_addr,
    output logic                    mem_wen,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_wmask,
    input  logic                    mem_resp_valid,
    input  logic [DATA_WIDTH-1:0]   mem_resp_data
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT);

    localparam logic OWN_IFU = 1'b0;
    localparam logic OWN_LSU = 1'b1;

    logic [1:0]              state_q, state_d;
    logic                    owner_q, owner_d;
    logic                    last_q,  last_d;
    logic [DATA_WIDTH-1:0]   addr_q,  addr_d;
    logic                    wen_q,   wen_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [DATA_WIDTH/8-1:0] wmask_q, wmask_d;
    logic [7:0]              cnt_q,   cnt_d;

    logic grant_lsu, grant_ifu;
    logic in_idle, in_req, in_resp;
    logic timeout_hit, resp_done;
    logic [DATA_WIDTH-1:0] resp_data;

    // Outputs are gated with rst so nothing leaks combinationally while reset is held.
    assign in_idle = (state_q == S_IDLE) && !rst;
    assign in_req  = (state_q == S_REQ)  && !rst;
    assign in_resp = (state_q == S_RESP) && !rst;

    // On a tie the requester that did not win last time goes first.
    assign grant_lsu = lsu_req_valid && (!ifu_req_valid || (last_q == OWN_IFU));
    assign grant_ifu = ifu_req_valid && !grant_lsu;

    assign ifu_req_ready = in_idle && grant_ifu;
    assign lsu_req_ready = in_idle && grant_lsu;

    // A response landing in the same cycle as the limit is treated as normal.
    assign timeout_hit = (cnt_q == TO_LIMIT) && !mem_resp_valid;
    assign resp_done   = in_resp && (mem_resp_valid || timeout_hit);
    assign resp_data   = mem_resp_valid ? mem_resp_data : '0;

    assign ifu_resp_valid = resp_done && (owner_q == OWN_IFU);
    assign ifu_resp_data  = ifu_resp_valid ? resp_data : '0;
    assign ifu_resp_err   = ifu_resp_valid && timeout_hit;

    assign lsu_resp_valid = resp_done && (owner_q == OWN_LSU);
    assign lsu_resp_data  = lsu_resp_valid ? resp_data : '0;
    assign lsu_resp_err   = lsu_resp_valid && timeout_hit;

    assign mem_req_valid = in_req;
    assign mem_addr      = addr_q;
    assign mem_wen       = wen_q;
    assign mem_wdata     = wdata_q;
    assign mem_wmask     = wmask_q;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        addr_d  = addr_q;
        wen_d   = wen_q;
        wdata_d = wdata_q;
        wmask_d = wmask_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (grant_lsu) begin
                    owner_d = OWN_LSU;
                    last_d  = OWN_LSU;
                    addr_d  = lsu_addr;
                    wen_d   = lsu_wen;
                    wdata_d = lsu_wdata;
                    wmask_d = lsu_wmask;
                    state_d = S_REQ;
                end else if (grant_ifu) begin
                    owner_d = OWN_IFU;
                    last_d  = OWN_IFU;
                    addr_d  = ifu_addr;
                    wen_d   = 1'b0;
                    wdata_d = '0;
                    wmask_d = '1;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (mem_req_ready) begin
                    cnt_d   = '0;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (mem_resp_valid || timeout_hit) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            owner_q <= OWN_IFU;
            last_q  <= OWN_IFU;
            addr_q  <= '0;
            wen_q   <= 1'b0;
            wdata_q <= '0;
            wmask_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
            wen_q   <= wen_d;
            wdata_q <= wdata_d;
            wmask_q <= wmask_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_ysyx_23060208_mem_arbiter.sv
// Directed bench for the IFU/LSU memory arbiter: per-cycle vector table plus
// hand sequences for mid-transaction reset and round-robin fairness.
module tb_ysyx_23060208_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        ifu_req_valid, ifu_req_ready;
    logic [31:0] ifu_addr;
    logic        ifu_resp_valid, ifu_resp_err;
    logic [31:0] ifu_resp_data;
    logic        lsu_req_valid, lsu_req_ready, lsu_wen;
    logic [31:0] lsu_addr, lsu_wdata;
    logic [3:0]  lsu_wmask;
    logic        lsu_resp_valid, lsu_resp_err;
    logic [31:0] lsu_resp_data;
    logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid;
    logic [31:0] mem_addr, mem_wdata, mem_resp_data;
    logic [3:0]  mem_wmask;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ysyx_23060208_mem_arbiter #(.DATA_WIDTH(32), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
        .ifu_resp_valid(ifu_resp_valid), .ifu_resp_data(ifu_resp_data), .ifu_resp_err(ifu_resp_err),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
        .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
        .lsu_resp_valid(lsu_resp_valid), .lsu_resp_data(lsu_resp_data), .lsu_resp_err(lsu_resp_err),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data)
    );

    // Output bundle: rdy(2) mem_req_valid addr wen wdata wmask | ifu rv/data/err | lsu rv/data/err
    logic [139:0] act;
    assign act = {ifu_req_ready, lsu_req_ready, mem_req_valid, mem_addr, mem_wen, mem_wdata,
                  mem_wmask, ifu_resp_valid, ifu_resp_data, ifu_resp_err,
                  lsu_resp_valid, lsu_resp_data, lsu_resp_err};

    typedef struct {
        logic        iv;
        logic [31:0] ia;
        logic        lv;
        logic [31:0] la;
        logic        lwe;
        logic [31:0] lwd;
        logic [3:0]  lwm;
        logic        mrdy;
        logic        mrv;
        logic [31:0] mrd;
        logic [139:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [139:0] E(input logic ir, input logic lr, input logic mv,
                                       input logic [31:0] ma, input logic mw, input logic [31:0] mwd,
                                       input logic [3:0] mwm, input logic irv, input logic [31:0] ird,
                                       input logic ie, input logic lrv, input logic [31:0] lrd,
                                       input logic le);
        return {ir, lr, mv, ma, mw, mwd, mwm, irv, ird, ie, lrv, lrd, le};
    endfunction

    task automatic add(input logic iv, input logic [31:0] ia, input logic lv, input logic [31:0] la,
                       input logic lwe, input logic [31:0] lwd, input logic [3:0] lwm,
                       input logic mrdy, input logic mrv, input logic [31:0] mrd,
                       input logic [139:0] e);
        vec_t v;
        v.iv = iv; v.ia = ia; v.lv = lv; v.la = la; v.lwe = lwe; v.lwd = lwd; v.lwm = lwm;
        v.mrdy = mrdy; v.mrv = mrv; v.mrd = mrd; v.exp = e;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [139:0] a, input logic [139:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s: got %h want %h", name, a, e);
        end
    endtask

    task automatic chk1(input string name, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s: got %h want %h", name, a, e);
        end
    endtask

    task automatic drive(input vec_t v);
        ifu_req_valid = v.iv; ifu_addr = v.ia;
        lsu_req_valid = v.lv; lsu_addr = v.la; lsu_wen = v.lwe; lsu_wdata = v.lwd; lsu_wmask = v.lwm;
        mem_req_ready = v.mrdy; mem_resp_valid = v.mrv; mem_resp_data = v.mrd;
    endtask

    initial begin
        logic [31:0] A1, A2, A3, A4, A5;
        A1 = 32'h8000_0000; A2 = 32'h8000_0100; A3 = 32'h8000_0004;
        A4 = 32'h0000_0010; A5 = 32'h8000_0008;

        // IFU read, minimum latency
        add(1, A1, 0, 0, 0, 0, 0, 0, 0, 0, E(1,0,0, 0,0,0,4'h0, 0,0,0, 0,0,0));
        add(0, 0,  0, 0, 0, 0, 0, 1, 0, 0, E(0,0,1, A1,0,0,4'hF, 0,0,0, 0,0,0));
        add(0, 0,  0, 0, 0, 0, 0, 0, 1, 32'h0000_0413, E(0,0,0, A1,0,0,4'hF, 1,32'h0000_0413,0, 0,0,0));
        // LSU write
        add(0, 0, 1, A2, 1, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, E(0,1,0, A1,0,0,4'hF, 0,0,0, 0,0,0));
        add(0, 0, 0, 0,  0, 0, 0, 1, 0, 0, E(0,0,1, A2,1,32'hDEAD_BEEF,4'hF, 0,0,0, 0,0,0));
        add(0, 0, 0, 0,  0, 0, 0, 0, 1, 32'h1234_5678, E(0,0,0, A2,1,32'hDEAD_BEEF,4'hF, 0,0,0, 1,32'h1234_5678,0));
        // stray response in IDLE is dropped
        add(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hCAFE_0001, E(0,0,0, A2,1,32'hDEAD_BEEF,4'hF, 0,0,0, 0,0,0));
        // IFU request, memory stalls 5 cycles with LSU waiting
        add(1, A3, 0, 0, 0, 0, 0, 0, 0, 0, E(1,0,0, A2,1,32'hDEAD_BEEF,4'hF, 0,0,0, 0,0,0));
        for (int i = 0; i < 5; i++)
            add(0, 0, 1, A4, 0, 32'h1111_1111, 4'h3, 0, 0, 0, E(0,0,1, A3,0,0,4'hF, 0,0,0, 0,0,0));
        add(0, 0, 1, A4, 0, 32'h1111_1111, 4'h3, 1, 0, 0, E(0,0,1, A3,0,0,4'hF, 0,0,0, 0,0,0));
        // RESP counts 0..3, then a response exactly at the limit is normal
        for (int i = 0; i < 4; i++)
            add(0, 0, 1, A4, 0, 32'h1111_1111, 4'h3, 0, 0, 0, E(0,0,0, A3,0,0,4'hF, 0,0,0, 0,0,0));
        add(0, 0, 1, A4, 0, 32'h1111_1111, 4'h3, 0, 1, 32'hAAAA_5555, E(0,0,0, A3,0,0,4'hF, 1,32'hAAAA_5555,0, 0,0,0));
        // LSU read that times out
        add(0, 0, 1, A4, 0, 32'h1111_1111, 4'h3, 0, 0, 0, E(0,1,0, A3,0,0,4'hF, 0,0,0, 0,0,0));
        add(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, E(0,0,1, A4,0,32'h1111_1111,4'h3, 0,0,0, 0,0,0));
        for (int i = 0; i < 4; i++)
            add(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'hFFFF_FFFF, E(0,0,0, A4,0,32'h1111_1111,4'h3, 0,0,0, 0,0,0));
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'hFFFF_FFFF, E(0,0,0, A4,0,32'h1111_1111,4'h3, 0,0,0, 1,0,1));
        // arbiter accepts again after the timeout
        add(1, A5, 0, 0, 0, 0, 0, 0, 0, 0, E(1,0,0, A4,0,32'h1111_1111,4'h3, 0,0,0, 0,0,0));
        add(0, 0,  0, 0, 0, 0, 0, 0, 0, 0, E(0,0,1, A5,0,0,4'hF, 0,0,0, 0,0,0));

        // reset state with requests pending
        rst = 1'b1;
        ifu_req_valid = 1; ifu_addr = A1; lsu_req_valid = 1; lsu_addr = A2;
        lsu_wen = 0; lsu_wdata = 0; lsu_wmask = 0;
        mem_req_ready = 0; mem_resp_valid = 0; mem_resp_data = 0;
        @(negedge clk);
        chk("reset_outputs", act, '0);
        @(posedge clk); #1;
        rst = 1'b0;

        foreach (vecs[i]) begin
            drive(vecs[i]);
            @(negedge clk);
            chk($sformatf("row%0d", i), act, vecs[i].exp);
            @(posedge clk); #1;
        end

        // move into RESP, then reset mid-transaction
        ifu_req_valid = 0; lsu_req_valid = 0; mem_req_ready = 1; mem_resp_valid = 0;
        @(negedge clk);
        chk1("req_before_reset", {31'd0, mem_req_valid}, 32'd1);
        @(posedge clk); #1;
        rst = 1; mem_req_ready = 0; ifu_req_valid = 1; lsu_req_valid = 1;
        mem_resp_valid = 1; mem_resp_data = 32'h5A5A_5A5A;
        @(negedge clk);
        chk("midreset_outputs", act, '0);
        @(posedge clk); #1;
        rst = 0; ifu_req_valid = 0; lsu_req_valid = 0;
        @(negedge clk);
        chk("stray_after_reset", act, '0);
        @(posedge clk); #1;
        mem_resp_valid = 0;

        // both valid continuously: LSU, IFU, LSU, IFU
        ifu_req_valid = 1; ifu_addr = 32'h0000_0100;
        lsu_req_valid = 1; lsu_addr = 32'h0000_0200; lsu_wen = 0; lsu_wdata = 0; lsu_wmask = 4'hF;
        for (int k = 0; k < 4; k++) begin
            logic lsu_win;
            lsu_win = (k % 2 == 0);
            mem_req_ready = 0; mem_resp_valid = 0;
            @(negedge clk);
            chk1($sformatf("fair_grant%0d", k), {30'd0, ifu_req_ready, lsu_req_ready},
                 lsu_win ? 32'd1 : 32'd2);
            @(posedge clk); #1;
            mem_req_ready = 1;
            @(negedge clk);
            chk1($sformatf("fair_addr%0d", k), mem_req_valid ? mem_addr : 32'hFFFF_FFFF,
                 lsu_win ? 32'h0000_0200 : 32'h0000_0100);
            @(posedge clk); #1;
            mem_req_ready = 0; mem_resp_valid = 1; mem_resp_data = 32'h50 + 32'(k);
            @(negedge clk);
            chk1($sformatf("fair_resp%0d", k), {30'd0, ifu_resp_valid, lsu_resp_valid},
                 lsu_win ? 32'd1 : 32'd2);
            chk1($sformatf("fair_data%0d", k), lsu_win ? lsu_resp_data : ifu_resp_data,
                 32'h50 + 32'(k));
            @(posedge clk); #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ysyx_23060208_mem_arbiter.md
# ysyx_23060208_mem_arbiter

- Arbitrates one shared memory port between the instruction-fetch requester (IFU) and the load/store requester (LSU).
- Sits between both requesters and the single SRAM/bus port.
- Allows one outstanding transaction at a time; grants are round-robin between the two requesters.
- Routes each response back to the requester that owns it and aborts stalled transactions with a timeout error.

## Interface
- DATA_WIDTH, 32, data and address width.
- TIMEOUT, 255, maximum number of cycles spent in RESP before the transaction is aborted; range 1..255.
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- ifu_req_valid  in  1  IFU read request.
- ifu_req_ready  out  1  IFU request accepted this cycle.
- ifu_addr  in  DATA_WIDTH  IFU read address.
- ifu_resp_valid  out  1  IFU response strobe, one cycle.
- ifu_resp_data  out  DATA_WIDTH  IFU read data.
- ifu_resp_err  out  1  IFU transaction timed out.
- lsu_req_valid  in  1  LSU request.
- lsu_req_ready  out  1  LSU request accepted this cycle.
- lsu_addr  in  DATA_WIDTH  LSU address.
- lsu_wen  in  1  1 = write, 0 = read.
- lsu_wdata  in  DATA_WIDTH  LSU write data.
- lsu_wmask  in  DATA_WIDTH/8  LSU byte-enable mask.
- lsu_resp_valid  out  1  LSU response strobe; issued for both reads and writes.
- lsu_resp_data  out  DATA_WIDTH  LSU read data; don't-care on writes.
- lsu_resp_err  out  1  LSU transaction timed out.
- mem_req_valid  out  1  request to memory.
- mem_req_ready  in  1  memory accepts request.
- mem_addr  out  DATA_WIDTH  memory address.
- mem_wen  out  1  memory write enable.
- mem_wdata  out  DATA_WIDTH  memory write data.
- mem_wmask  out  DATA_WIDTH/8  memory byte-enable mask.
- mem_resp_valid  in  1  memory response strobe.
- mem_resp_data  in  DATA_WIDTH  memory read data.

## Operation
- State machine states: IDLE, REQ, RESP. Reset state is IDLE.
- Registers:
  - owner (0 = IFU, 1 = LSU).
  - last_grant; resets to IFU, so the LSU wins the first tie.
  - Latched request fields: addr, wen, wdata, wmask.
  - Timeout counter cnt, 8 bits.
- IDLE, arbitration:
  - Winner = the only valid requester.
  - If both are valid, winner = the requester that is not last_grant.
  - The winner's req_ready = 1, combinational; the loser's req_ready = 0.
  - On handshake: latch the winner's fields (IFU: wen = 0, wmask = all-ones, wdata = 0), set owner and last_grant, go to REQ.
- REQ:
  - mem_req_valid = 1, driving the latched fields.
  - On mem_req_ready: clear cnt, go to RESP.
  - No timeout applies in REQ.
- RESP:
  - On mem_resp_valid: owner's resp_valid = 1 and resp_data = mem_resp_data, both combinational and in the same cycle; resp_err = 0; go to IDLE.
  - Otherwise cnt increments.
  - When cnt == TIMEOUT and mem_resp_valid = 0: owner's resp_valid = 1, resp_err = 1, resp_data = 0; go to IDLE.
- Outside RESP:
  - mem_resp_valid is ignored and discarded; no response is forwarded.
  - Both req_ready are 0 in REQ and RESP.
- The non-owner's resp_valid, resp_err and resp_data are always 0.
- mem_addr, mem_wen, mem_wdata and mem_wmask always show the latched registers. They are meaningful only while mem_req_valid = 1.

## Timing
- Reset:
  - While rst = 1, every output is 0, including both req_ready.
  - state = IDLE, cnt = 0, latched fields = 0, last_grant = IFU.
  - Reset asserted mid-transaction aborts it with no response to the requester; a later stray mem_resp_valid is discarded.
- Minimum latency:
  - Cycle 0: request accepted.
  - Cycle 1: mem_req_valid.
  - Cycle 2 (memory ready in cycle 1, responds in cycle 2): resp_valid.
- Back-to-back: the next acceptance can happen in the cycle after resp_valid. Peak throughput is one transaction per 3 cycles.
- Requests held valid while not ready must stay stable; the arbiter samples fields only in the handshake cycle.
- A response arriving in the same cycle that cnt reaches TIMEOUT counts as a normal response (err = 0).
- Fairness: with both requesters valid continuously, grants alternate LSU, IFU, LSU, ...

## Test plan
- Single IFU read, addr 0x8000_0000; memory ready immediately, returns 0x0000_0413 one cycle later -> ifu_resp_valid in cycle 2 with data 0x0000_0413; lsu_resp_valid stays 0.
- LSU write, addr 0x8000_0100, wdata 0xDEAD_BEEF, wmask 0xF -> mem_wen = 1 and fields match while mem_req_valid = 1; lsu_resp_valid = 1 on the memory ack.
- IFU and LSU both valid for 4 transactions -> grant order LSU, IFU, LSU, IFU; each resp_valid goes only to its owner.
- mem_req_ready held 0 for 5 cycles -> mem_req_valid stays 1 with stable fields; both req_ready stay 0; no timeout fires.
- TIMEOUT = 4 and memory never responds -> owner resp_valid = 1, resp_err = 1, resp_data = 0 after 4 counted cycles in RESP; arbiter returns to IDLE and accepts the next request.
- rst pulsed while in RESP, then mem_resp_valid pulsed after reset -> all outputs 0 during reset; the stray response is not forwarded; the next request behaves as the first after reset (LSU wins a tie).
